lane_accum_unit: RTL

// - Parametrised burst accumulator for the DC datapath.
// - Selects one word from a multi-word input bus and splits it into LANES signed lanes.
// - Sums each lane over an enable burst. When the burst ends it presents a

---
 rtl/lane_accum_pkg.sv | 35 +++
 rtl/lane_accum_unit_if.sv | 27 ++
 rtl/lane_accum_slice.sv | 56 +++++
 rtl/lane_accum_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lane_accum_pkg.sv
// Shared types and arithmetic helpers for the lane burst accumulator.
package lane_accum_pkg;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam int MAX_W = 64;

  // Extra MSB lets the word-select port express out-of-range indices.
  function automatic int idx_w(input int nwords);
    return $clog2(nwords) + 1;
  endfunction

  // Returns {ovf, sum}: operands are already sign-extended from acc_w bits.
  function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] acc,
                                             input logic signed [MAX_W-1:0] lane,
                                             input int                      acc_w,
                                             input bit                      sat);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] res;
    logic                    ovf;
    sum = acc + lane;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = (sum > hi) || (sum < lo);
    res = sum;
    if (ovf) begin
      if (sat) res = (sum > hi) ? hi : lo;
      else     res = (sum <<< (MAX_W - acc_w)) >>> (MAX_W - acc_w);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/lane_accum_unit_if.sv
// Input word bus, burst controls and registered burst results of lane_accum_unit.
interface lane_accum_unit_if
  import lane_accum_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int LANES  = 2,
  parameter int LANE_W = 16,
  parameter int OUT_W  = 24,
  parameter int CNT_W  = 8
) ();
  localparam int IDX_W = idx_w(NWORDS);

  logic [IDX_W-1:0]                     index;
  logic [NWORDS-1:0][LANES*LANE_W-1:0]  data;
  logic                                 en;
  logic                                 clr;
  logic [LANES*OUT_W-1:0]               res;
  logic                                 res_valid;
  logic [CNT_W-1:0]                     cnt;
  logic [LANES-1:0]                     ovf;
  logic                                 idx_err;

  modport master (output index, data, en, clr,
                  input  res, res_valid, cnt, ovf, idx_err);
  modport slave  (input  index, data, en, clr,
                  output res, res_valid, cnt, ovf, idx_err);
endinterface

// File: rtl/lane_accum_slice.sv
// One signed lane accumulator with wrap/saturate add and sticky overflow.
// Latency: acc/ovf update on the edge after load/add/clear.
// Backpressure: none, controls are single-cycle commands from the top FSM.
module lane_accum_slice
  import lane_accum_pkg::*;
#(
  parameter int LANE_W = 16,
  parameter int ACC_W  = 22,
  parameter int SAT    = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load,
  input  logic                     add,
  input  logic                     clear,
  input  logic signed [LANE_W-1:0] lane,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic [MAX_W:0]            add_res;
  logic [MAX_W-1-ACC_W:0]    unused_hi;

  assign add_res   = sat_add(MAX_W'(acc_q), MAX_W'(lane), ACC_W, SAT != 0);
  assign unused_hi = add_res[MAX_W-1:ACC_W];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      // First sample of a burst cannot overflow since ACC_W > LANE_W.
      acc_d = ACC_W'(lane);
      ovf_d = 1'b0;
    end else if (add) begin
      acc_d = add_res[ACC_W-1:0];
      ovf_d = ovf_q | add_res[MAX_W];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/lane_accum_unit.sv
// Burst accumulator: selects a word, sums its signed lanes while en is high.
// Latency: res/res_valid register on the edge sampling the first en=0 of a burst.
// Backpressure: none; clr aborts the burst without producing a result.
module lane_accum_unit
  import lane_accum_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int LANES  = 2,
  parameter int LANE_W = 16,
  parameter int ACC_W  = 22,
  parameter int OUT_W  = 24,
  parameter int SAT    = 0,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rstn,
  lane_accum_unit_if.slave  bus
);
  localparam int IDX_W  = idx_w(NWORDS);
  localparam int WORD_W = LANES * LANE_W;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              smp_cnt_q, smp_cnt_d;
  logic                          ierr_q, ierr_d;
  logic [LANES*OUT_W-1:0]        res_q, res_d;
  logic                          res_valid_q, res_valid_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0]              ovf_out_q, ovf_out_d;
  logic                          idx_err_q, idx_err_d;

  logic                          idx_ok;
  logic [WORD_W-1:0]             word;
  logic                          load, add, capture, clear;
  logic [LANES-1:0][ACC_W-1:0]   acc;
  logic [LANES-1:0]              lane_ovf;

  // Out-of-range index selects nothing, so every lane contributes zero.
  always_comb begin
    idx_ok = (bus.index < IDX_W'(NWORDS));
    word   = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_ok && (bus.index == IDX_W'(i))) word = bus.data[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.en)  state_d = ACC;
        ACC:     if (!bus.en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load    = !bus.clr && (state_q == IDLE) &&  bus.en;
    add     = !bus.clr && (state_q == ACC)  &&  bus.en;
    capture = !bus.clr && (state_q == ACC)  && !bus.en;
    clear   = bus.clr || capture;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_accum_slice #(.LANE_W(LANE_W), .ACC_W(ACC_W), .SAT(SAT)) u_slice (
      .clk   (clk),
      .rstn  (rstn),
      .load  (load),
      .add   (add),
      .clear (clear),
      .lane  (word[k*LANE_W +: LANE_W]),
      .acc   (acc[k]),
      .ovf   (lane_ovf[k])
    );
  end

  always_comb begin
    smp_cnt_d   = smp_cnt_q;
    ierr_d      = ierr_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    ovf_out_d   = ovf_out_q;
    idx_err_d   = idx_err_q;
    res_valid_d = capture;
    if (clear) begin
      smp_cnt_d = '0;
      ierr_d    = 1'b0;
    end else if (load) begin
      smp_cnt_d = CNT_W'(1);
      ierr_d    = !idx_ok;
    end else if (add) begin
      smp_cnt_d = (smp_cnt_q == '1) ? smp_cnt_q : smp_cnt_q + CNT_W'(1);
      ierr_d    = ierr_q | !idx_ok;
    end
    if (capture) begin
      for (int k = 0; k < LANES; k++) res_d[k*OUT_W +: OUT_W] = OUT_W'($signed(acc[k]));
      cnt_d     = smp_cnt_q;
      ovf_out_d = lane_ovf;
      idx_err_d = ierr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_cnt_q   <= '0;
      ierr_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      ovf_out_q   <= '0;
      idx_err_q   <= 1'b0;
    end else begin
      smp_cnt_q   <= smp_cnt_d;
      ierr_q      <= ierr_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      ovf_out_q   <= ovf_out_d;
      idx_err_q   <= idx_err_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.cnt       = cnt_q;
  assign bus.ovf       = ovf_out_q;
  assign bus.idx_err   = idx_err_q;
endmodule
